// File: rtl/ram_module_param_if.sv
// Request/response bundle between a requester (master) and ram_module_param (slave).
// Busy from the slave must gate every access the master issues.
interface ram_module_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              en;
    logic              we;
    logic              clr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic              valid;
    logic              busy;

    modport master (
        output en, we, clr, addr, din,
        input  dout, valid, busy
    );

    modport slave (
        input  en, we, clr, addr, din,
        output dout, valid, busy
    );
endinterface

// File: rtl/ram_module_param.sv
// Single-port synchronous RAM with a built-in clear sequencer (fills INIT_VAL after reset or CLR).
// Optional macro RAM_OUTREG_EN adds a second output register stage (2-cycle read latency).
module ram_module_param #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 8,
    parameter int                DEPTH    = 2**ADDR_W,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    ram_module_param_if.slave bus
);
    typedef enum logic {CLEAR, READY} state_e;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    state_e            state_q;
    logic [ADDR_W-1:0] clr_addr_q;
    logic [DATA_W-1:0] dout_q;
    logic              valid_q;
    logic              busy_q;

    logic              in_range;
    logic              mem_we_d;
    logic [ADDR_W-1:0] mem_waddr_d;
    logic [DATA_W-1:0] mem_wdata_d;

    assign in_range = ({1'b0, bus.addr} < DEPTH_W);

    // Single write port shared by the clear sequencer and requester writes.
    always_comb begin
        mem_we_d    = 1'b0;
        mem_waddr_d = clr_addr_q;
        mem_wdata_d = INIT_VAL;
        if (!rst_i) begin
            if (state_q == CLEAR) begin
                mem_we_d = 1'b1;
            end else if (!bus.clr && bus.en && bus.we && in_range) begin
                mem_we_d    = 1'b1;
                mem_waddr_d = bus.addr;
                mem_wdata_d = bus.din;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we_d) begin
            mem_q[mem_waddr_d] <= mem_wdata_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
            dout_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            case (state_q)
                CLEAR: begin
                    valid_q <= 1'b0;
                    if (bus.clr) begin
                        clr_addr_q <= '0;
                    end else if (clr_addr_q == LAST_ADDR) begin
                        state_q <= READY;
                        busy_q  <= 1'b0;
                    end else begin
                        clr_addr_q <= clr_addr_q + 1'b1;
                    end
                end
                READY: begin
                    if (bus.clr) begin
                        state_q    <= CLEAR;
                        clr_addr_q <= '0;
                        busy_q     <= 1'b1;
                        valid_q    <= 1'b0;
                    end else if (bus.en) begin
                        // Read-first: old contents are returned even on a write.
                        dout_q  <= in_range ? mem_q[bus.addr] : '0;
                        valid_q <= 1'b1;
                    end else begin
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= CLEAR;
                    clr_addr_q <= '0;
                    busy_q     <= 1'b1;
                    valid_q    <= 1'b0;
                end
            endcase
        end
    end

`ifdef RAM_OUTREG_EN
    logic [DATA_W-1:0] dout2_q;
    logic              valid2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dout2_q  <= '0;
            valid2_q <= 1'b0;
        end else begin
            dout2_q  <= dout_q;
            valid2_q <= valid_q;
        end
    end

    assign bus.dout  = dout2_q;
    assign bus.valid = valid2_q;
`else
    assign bus.dout  = dout_q;
    assign bus.valid = valid_q;
`endif

    assign bus.busy = busy_q;
endmodule

// File: tb/tb_ram_module_param.sv
// Bench for ram_module_param: a full-depth and a reduced-depth (200-word) instance share stimulus,
// each compared every cycle against a word-array reference model.
module tb_ram_module_param;
`ifdef RAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int D0 = 256;
    localparam int D1 = 200;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    ram_module_param_if #(.DATA_W(8), .ADDR_W(8)) bus0 ();
    ram_module_param_if #(.DATA_W(8), .ADDR_W(8)) bus1 ();

    ram_module_param #(.DATA_W(8), .ADDR_W(8), .DEPTH(D0), .INIT_VAL(8'h00)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .bus(bus0)
    );
    ram_module_param #(.DATA_W(8), .ADDR_W(8), .DEPTH(D1), .INIT_VAL(8'h00)) dut_s (
        .clk_i(clk_i), .rst_i(rst_i), .bus(bus1)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: busy flag plus remaining clear edges, and a plain word array per instance.
    bit         m_busy  [2];
    int         m_cnt   [2];
    logic [7:0] m_mem   [2][256];
    logic [7:0] m_d1    [2];
    logic [7:0] m_d2    [2];
    bit         m_v1    [2];
    bit         m_v2    [2];
    int         m_depth [2];

    function automatic void model_step(input int u, input bit rst, input bit en, input bit we,
                                       input bit clr, input logic [7:0] addr, input logic [7:0] din);
        logic [7:0] nd2;
        bit         nv2;
        if (rst) begin
            m_busy[u] = 1'b1;
            m_cnt[u]  = m_depth[u];
            m_d1[u] = 8'h00; m_v1[u] = 1'b0;
            m_d2[u] = 8'h00; m_v2[u] = 1'b0;
            return;
        end
        nd2 = m_d1[u];
        nv2 = m_v1[u];
        if (m_busy[u]) begin
            m_v1[u] = 1'b0;
            if (clr) begin
                m_cnt[u] = m_depth[u];
            end else begin
                m_cnt[u]--;
                if (m_cnt[u] == 0) begin
                    m_busy[u] = 1'b0;
                    for (int i = 0; i < 256; i++) m_mem[u][i] = 8'h00;
                end
            end
        end else if (clr) begin
            m_busy[u] = 1'b1;
            m_cnt[u]  = m_depth[u];
            m_v1[u]   = 1'b0;
        end else if (en) begin
            if (int'(addr) < m_depth[u]) begin
                m_d1[u] = m_mem[u][addr];
                if (we) m_mem[u][addr] = din;
            end else begin
                m_d1[u] = 8'h00;
            end
            m_v1[u] = 1'b1;
        end else begin
            m_v1[u] = 1'b0;
        end
        m_d2[u] = nd2;
        m_v2[u] = nv2;
    endfunction

    function automatic logic [7:0] exp_d(input int u);
        return (LAT == 1) ? m_d1[u] : m_d2[u];
    endfunction

    function automatic bit exp_v(input int u);
        return (LAT == 1) ? m_v1[u] : m_v2[u];
    endfunction

    logic [7:0] q0_d[$];
    bit         q0_v[$];
    logic [7:0] q1_d[$];
    bit         q1_v[$];

    task automatic cycle(input bit rst, input bit en, input bit we, input bit clr,
                         input logic [7:0] addr, input logic [7:0] din);
        rst_i = rst;
        bus0.en = en; bus0.we = we; bus0.clr = clr; bus0.addr = addr; bus0.din = din;
        bus1.en = en; bus1.we = we; bus1.clr = clr; bus1.addr = addr; bus1.din = din;
        @(posedge clk_i);
        model_step(0, rst, en, we, clr, addr, din);
        model_step(1, rst, en, we, clr, addr, din);
        #1;
        chk("busy0",  bus0.busy,  m_busy[0]);
        chk("valid0", bus0.valid, exp_v(0));
        chk("dout0",  bus0.dout,  exp_d(0));
        chk("busy1",  bus1.busy,  m_busy[1]);
        chk("valid1", bus1.valid, exp_v(1));
        chk("dout1",  bus1.dout,  exp_d(1));
        q0_d.push_back(bus0.dout); q0_v.push_back(bus0.valid);
        q1_d.push_back(bus1.dout); q1_v.push_back(bus1.valid);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [7:0] a);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, a, 8'h00);
    endtask

    task automatic clear_hist();
        q0_d.delete(); q0_v.delete(); q1_d.delete(); q1_v.delete();
    endtask

    // Idle edges until the full-depth instance drops Busy; returns each instance's edge count.
    task automatic wait_idle(output int n0, output int n1);
        int k;
        k  = 0;
        n1 = -1;
        if (bus1.busy !== 1'b1) n1 = 0;
        while (bus0.busy === 1'b1 && k < 1000) begin
            idle();
            k++;
            if (n1 < 0 && bus1.busy !== 1'b1) n1 = k;
        end
        n0 = k;
        if (n1 < 0) n1 = k;
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n0, n1;
        logic [7:0] a, d;
        bit en, we, clr, rst;

        m_depth[0] = D0;
        m_depth[1] = D1;
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 256; i++) m_mem[u][i] = 8'h00;
        end
        bus0.en = 0; bus0.we = 0; bus0.clr = 0; bus0.addr = 0; bus0.din = 0;
        bus1.en = 0; bus1.we = 0; bus1.clr = 0; bus1.addr = 0; bus1.din = 0;

        // Reset and initial clear
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("rst_busy",  bus0.busy,  1'b1);
        chk("rst_valid", bus0.valid, 1'b0);
        chk("rst_dout",  bus0.dout,  8'h00);
        wait_idle(n0, n1);
        chk("clr_len0", n0, D0);
        chk("clr_len1", n1, D1);
        clear_hist();
        rd(8'h00); rd(8'h7F); rd(8'hFF); idle(); idle();
        for (int i = 0; i < 3; i++) begin
            chk("init_rd_d", q0_d[LAT-1+i], 8'h00);
            chk("init_rd_v", q0_v[LAT-1+i], 1'b1);
        end

        // Write/read back-to-back
        wr(8'h10, 8'hA5); wr(8'h11, 8'h3C);
        clear_hist();
        rd(8'h10); rd(8'h11); idle(); idle();
        chk("wr_rd_10", q0_d[LAT-1], 8'hA5);
        chk("wr_rd_11", q0_d[LAT],   8'h3C);
        chk("wr_rd_v0", q0_v[LAT-1], 1'b1);
        chk("wr_rd_v1", q0_v[LAT],   1'b1);
        chk("wr_rd_v2", q0_v[LAT+1], 1'b0);

        // Read-first on write
        wr(8'h20, 8'h11);
        clear_hist();
        wr(8'h20, 8'h22); rd(8'h20); idle(); idle();
        chk("rf_old", q0_d[LAT-1], 8'h11);
        chk("rf_new", q0_d[LAT],   8'h22);

        // CLR mid-op, then restart of the clear
        wr(8'h05, 8'hFF);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 8'h06, 8'h77);
        repeat (10) idle();
        chk("clr_busy_mid", bus0.busy, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        wait_idle(n0, n1);
        chk("clr_restart0", n0, D0);
        chk("clr_restart1", n1, D1);
        clear_hist();
        rd(8'h05); rd(8'h06); idle(); idle();
        chk("clr_05", q0_d[LAT-1], 8'h00);
        chk("clr_06", q0_d[LAT],   8'h00);

        // Out-of-range on the 200-word instance
        clear_hist();
        wr(8'hC8, 8'h55); rd(8'hC8); idle(); idle();
        chk("oor_dout", q1_d[LAT], 8'h00);
        chk("oor_vld",  q1_v[LAT], 1'b1);
        chk("full_c8",  q0_d[LAT], 8'h55);
        for (int i = 0; i < D1; i++) rd(8'(i));

        // Reset mid-stream
        rd(8'h10); rd(8'hC8);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
        chk("mid_rst_d", bus0.dout,  8'h00);
        chk("mid_rst_v", bus0.valid, 1'b0);
        wait_idle(n0, n1);
        chk("mid_rst_len0", n0, D0);

        // Randomized traffic, addresses clustered around the short-depth boundary
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 999) == 0);
            clr = ($urandom_range(0, 299) == 0);
            en  = ($urandom_range(0, 9) < 7);
            we  = $urandom_range(0, 1) == 1;
            a   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(8'hC0 + $urandom_range(0, 15));
            d   = 8'($urandom);
            cycle(rst, en, we, clr, a, d);
        end
        wait_idle(n0, n1);
        chk("final_idle", bus0.busy, 1'b0);
        for (int i = 0; i < 256; i++) rd(8'(i));
        idle(); idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
